// File: rtl/inst_fetch_seq.sv
// Program counter and fetch sequencer: start/load, branch/jump, call/return through a
// circular return-address stack, stall, and halt/done signalling.
module inst_fetch_seq #(
  parameter int PC_W      = 10,
  parameter int RAS_DEPTH = 4,
  parameter int RAS_CNT_W = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [PC_W-1:0]      StartAddr,
  input  logic                 Stall,
  input  logic                 Halt,
  input  logic                 Jump,
  input  logic                 BranchOnEq,
  input  logic                 BranchOnNe,
  input  logic                 ALU_Zflag,
  input  logic                 RelMode,
  input  logic [PC_W-1:0]      Target,
  input  logic                 Call,
  input  logic                 Ret,
  output logic [PC_W-1:0]      ProgCtr,
  output logic                 Running,
  output logic                 Done,
  output logic                 RasOverflow,
  output logic                 RasUnderflow,
  output logic [RAS_CNT_W-1:0] RasCount
);
  localparam int SP_W = $clog2(RAS_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]      state;
  logic [PC_W-1:0] ras [RAS_DEPTH];
  logic [SP_W-1:0] sp, sp_dec;
  logic [PC_W-1:0] pc_inc, tgt, top;
  logic            ras_full, ras_empty, do_call, do_br;

  // sp points at the next free slot; wrapping it makes a full push overwrite the oldest entry
  assign sp_dec    = sp - SP_W'(1);
  assign top       = ras[sp_dec];
  assign pc_inc    = ProgCtr + PC_W'(1);
  // same-width add already gives sign-extended offset arithmetic modulo 2^PC_W
  assign tgt       = RelMode ? ProgCtr + Target : Target;
  assign ras_full  = (RasCount == RAS_CNT_W'(RAS_DEPTH));
  assign ras_empty = (RasCount == '0);
  assign do_call   = !Reset && !Start && (state == RUN) && !Halt && !Stall && !Ret && Call;
  assign do_br     = Jump || (BranchOnEq && ALU_Zflag) || (BranchOnNe && !ALU_Zflag);

  assign Running = (state == RUN);
  assign Done    = (state == HALTED);

  always_ff @(posedge Clk) begin
    if (do_call) ras[sp] <= pc_inc;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      ProgCtr      <= '0;
      sp           <= '0;
      RasCount     <= '0;
      RasOverflow  <= 1'b0;
      RasUnderflow <= 1'b0;
    end else if (Start) begin
      state        <= LOAD;
      ProgCtr      <= StartAddr;
      sp           <= '0;
      RasCount     <= '0;
      RasOverflow  <= 1'b0;
      RasUnderflow <= 1'b0;
    end else begin
      case (state)
        LOAD: state <= RUN;
        RUN: begin
          if (Halt) begin
            state <= HALTED;
          end else if (!Stall) begin
            if (Ret) begin
              if (ras_empty) begin
                RasUnderflow <= 1'b1;
                state        <= HALTED;
              end else begin
                ProgCtr  <= top;
                sp       <= sp_dec;
                RasCount <= RasCount - RAS_CNT_W'(1);
              end
            end else if (Call) begin
              ProgCtr <= tgt;
              sp      <= sp + SP_W'(1);
              if (ras_full) RasOverflow <= 1'b1;
              else          RasCount    <= RasCount + RAS_CNT_W'(1);
            end else if (do_br) begin
              ProgCtr <= tgt;
            end else begin
              ProgCtr <= pc_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_seq.sv
// Self-checking bench: directed test-plan scenarios plus random control traffic,
// compared every cycle against a queue-based behavioural model.
module tb_inst_fetch_seq;
  localparam int PC_W = 10, RAS_DEPTH = 4, RAS_CNT_W = 3;
  localparam int MASK = (1 << PC_W) - 1;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALTED = 3;

  logic                 Clk, Reset, Start, Stall, Halt, Jump, BranchOnEq, BranchOnNe;
  logic                 ALU_Zflag, RelMode, Call, Ret;
  logic [PC_W-1:0]      StartAddr, Target, ProgCtr;
  logic                 Running, Done, RasOverflow, RasUnderflow;
  logic [RAS_CNT_W-1:0] RasCount;

  inst_fetch_seq #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH), .RAS_CNT_W(RAS_CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
    .Halt(Halt), .Jump(Jump), .BranchOnEq(BranchOnEq), .BranchOnNe(BranchOnNe),
    .ALU_Zflag(ALU_Zflag), .RelMode(RelMode), .Target(Target), .Call(Call), .Ret(Ret),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .RasOverflow(RasOverflow),
    .RasUnderflow(RasUnderflow), .RasCount(RasCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass = 0, n_total = 0;
  int m_pc, m_st;
  int m_q[$];
  bit m_ovf, m_unf;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model of one rising edge, from the behavioural rules
  task automatic model_edge();
    int off, t;
    off = Target[PC_W-1] ? int'(Target) - (1 << PC_W) : int'(Target);
    t   = RelMode ? ((m_pc + off) & MASK) : int'(Target);
    if (Reset) begin
      m_st = M_IDLE; m_pc = 0; m_q.delete(); m_ovf = 0; m_unf = 0;
    end else if (Start) begin
      m_st = M_LOAD; m_pc = int'(StartAddr); m_q.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_st == M_LOAD) begin
      m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (Halt) m_st = M_HALTED;
      else if (Stall) ;
      else if (Ret) begin
        if (m_q.size() == 0) begin m_unf = 1; m_st = M_HALTED; end
        else m_pc = m_q.pop_back();
      end else if (Call) begin
        m_q.push_back((m_pc + 1) & MASK);
        if (m_q.size() > RAS_DEPTH) begin void'(m_q.pop_front()); m_ovf = 1; end
        m_pc = t;
      end else if (Jump || (BranchOnEq && ALU_Zflag) || (BranchOnNe && !ALU_Zflag)) m_pc = t;
      else m_pc = (m_pc + 1) & MASK;
    end
  endtask

  // One clock: advance model, then compare every output just after the edge
  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    chk("ProgCtr", int'(ProgCtr), m_pc);
    chk("Running", int'(Running), int'(m_st == M_RUN));
    chk("Done", int'(Done), int'(m_st == M_HALTED));
    chk("RasCount", int'(RasCount), m_q.size());
    chk("RasOverflow", int'(RasOverflow), int'(m_ovf));
    chk("RasUnderflow", int'(RasUnderflow), int'(m_unf));
  endtask

  task automatic clr();
    Reset = 0; Start = 0; Stall = 0; Halt = 0; Jump = 0; BranchOnEq = 0; BranchOnNe = 0;
    ALU_Zflag = 0; RelMode = 0; Call = 0; Ret = 0; StartAddr = '0; Target = '0;
  endtask

  task automatic load(input int addr);
    clr(); Start = 1; StartAddr = PC_W'(addr); step();
    Start = 0; step();
    chk("load_pc", int'(ProgCtr), addr);
    chk("load_running", int'(Running), 1);
  endtask

  task automatic call_to(input int t);
    clr(); Call = 1; Target = PC_W'(t); step();
  endtask

  task automatic do_ret();
    clr(); Ret = 1; step();
  endtask

  initial begin
    clr(); Reset = 1;
    m_pc = 0; m_st = M_IDLE; m_ovf = 0; m_unf = 0;
    step(); step();
    chk("rst_pc", int'(ProgCtr), 0);
    chk("rst_running", int'(Running), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_cnt", int'(RasCount), 0);

    // Start held two cycles, then sequential fetch
    clr(); Start = 1; StartAddr = 10'h040; step();
    chk("start_pc", int'(ProgCtr), 'h040);
    step();
    Start = 0; step();
    chk("run_pc0", int'(ProgCtr), 'h040);
    chk("run_running", int'(Running), 1);
    step(); chk("run_pc1", int'(ProgCtr), 'h041);
    step(); chk("run_pc2", int'(ProgCtr), 'h042);
    step(); chk("run_pc3", int'(ProgCtr), 'h043);

    load('h010); BranchOnEq = 1; ALU_Zflag = 1; RelMode = 1; Target = 10'h3FE; step();
    chk("beq_rel", int'(ProgCtr), 'h00E);
    load('h010); BranchOnNe = 1; ALU_Zflag = 1; Target = 10'h200; step();
    chk("bne_not_taken", int'(ProgCtr), 'h011);
    load('h3FF); step();
    chk("pc_wrap", int'(ProgCtr), 'h000);

    load('h020); call_to('h100);
    chk("call_pc", int'(ProgCtr), 'h100);
    chk("call_cnt", int'(RasCount), 1);
    do_ret();
    chk("ret_pc", int'(ProgCtr), 'h021);
    chk("ret_cnt", int'(RasCount), 0);
    clr(); Call = 1; Ret = 1; Target = 10'h155; step();
    chk("callret_unf", int'(RasUnderflow), 1);
    chk("callret_done", int'(Done), 1);
    chk("callret_pc", int'(ProgCtr), 'h021);

    // Five nested calls into a 4-deep stack
    load('h000);
    call_to('h100); call_to('h200); call_to('h300); call_to('h050); call_to('h060);
    chk("ovf_flag", int'(RasOverflow), 1);
    chk("ovf_cnt", int'(RasCount), 4);
    do_ret(); chk("ret5", int'(ProgCtr), 'h051);
    do_ret(); chk("ret4", int'(ProgCtr), 'h301);
    do_ret(); chk("ret3", int'(ProgCtr), 'h201);
    do_ret(); chk("ret2", int'(ProgCtr), 'h101);
    do_ret();
    chk("ret_unf", int'(RasUnderflow), 1);
    chk("ret_unf_done", int'(Done), 1);
    chk("ret_unf_pc", int'(ProgCtr), 'h101);

    load('h080);
    clr(); Stall = 1; Jump = 1; Target = 10'h200;
    step(); step(); step();
    chk("stall_pc", int'(ProgCtr), 'h080);
    clr(); Halt = 1; step();
    chk("halt_done", int'(Done), 1);
    clr(); Jump = 1; Target = 10'h200; step();
    chk("halted_jump", int'(ProgCtr), 'h080);
    clr(); Start = 1; StartAddr = 10'h123; step();
    chk("restart_done", int'(Done), 0);
    chk("restart_pc", int'(ProgCtr), 'h123);

    load('h000); call_to('h100); call_to('h200);
    chk("mid_cnt", int'(RasCount), 2);
    clr(); Reset = 1; step();
    chk("midrst_pc", int'(ProgCtr), 0);
    chk("midrst_cnt", int'(RasCount), 0);
    chk("midrst_running", int'(Running), 0);
    chk("midrst_done", int'(Done), 0);

    // Random traffic
    load('h000);
    for (int i = 0; i < 3000; i++) begin
      Reset      = ($urandom_range(99) < 1);
      Start      = ($urandom_range(99) < 3);
      StartAddr  = PC_W'($urandom);
      Halt       = ($urandom_range(99) < 2);
      Stall      = ($urandom_range(99) < 10);
      Ret        = ($urandom_range(99) < 12);
      Call       = ($urandom_range(99) < 14);
      Jump       = ($urandom_range(99) < 10);
      BranchOnEq = ($urandom_range(99) < 20);
      BranchOnNe = ($urandom_range(99) < 20);
      ALU_Zflag  = 1'($urandom);
      RelMode    = 1'($urandom);
      Target     = PC_W'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
